// File: rtl/sram_arbiter_if.sv
// Port-side and pad-side signal bundle of the two-port SRAM arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the pad model.
interface sram_arbiter_if;
   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = 2;

   logic          p0_req;
   logic          p0_we;
   logic [BW-1:0] p0_be;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdat;
   logic          p0_ack;
   logic [DW-1:0] p0_rdat;

   logic          p1_req;
   logic          p1_we;
   logic [BW-1:0] p1_be;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdat;
   logic          p1_ack;
   logic [DW-1:0] p1_rdat;

   logic [AW-1:0] sram_addr;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic          sram_ub_n;
   logic          sram_lb_n;
   logic [DW-1:0] sram_dq_o;
   logic          sram_dq_oe;
   logic [DW-1:0] sram_dq_i;
   logic          busy;
   logic          gnt;

   modport slave (
      input  p0_req, p0_we, p0_be, p0_addr, p0_wdat,
      input  p1_req, p1_we, p1_be, p1_addr, p1_wdat,
      input  sram_dq_i,
      output p0_ack, p0_rdat, p1_ack, p1_rdat,
      output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      output sram_dq_o, sram_dq_oe, busy, gnt
   );

   modport master (
      output p0_req, p0_we, p0_be, p0_addr, p0_wdat,
      output p1_req, p1_we, p1_be, p1_addr, p1_wdat,
      output sram_dq_i,
      input  p0_ack, p0_rdat, p1_ack, p1_rdat,
      input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      input  sram_dq_o, sram_dq_oe, busy, gnt
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for a 16-bit asynchronous SRAM.
// Each state's strobes are registered on the edge that enters that state.
module sram_arbiter #(
   parameter int unsigned ACC_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   sram_arbiter_if.slave  bus
);
   localparam int unsigned AW    = 18;
   localparam int unsigned DW    = 16;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   logic             busy_q;
   logic             gnt_q;
   logic             ack0_q;
   logic             ack1_q;
   logic [DW-1:0]    rdat0_q;
   logic [DW-1:0]    rdat1_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    dq_o_q;
   logic             ce_n_q;
   logic             oe_n_q;
   logic             we_n_q;
   logic             ub_n_q;
   logic             lb_n_q;
   logic             dq_oe_q;

   logic             any_req_c;
   logic             win_c;
   logic             w_we_c;
   logic [1:0]       w_be_c;
   logic [AW-1:0]    w_addr_c;
   logic [DW-1:0]    w_wdat_c;

   // When both ports request, the port that did not own the last access wins
   assign any_req_c = bus.p0_req | bus.p1_req;
   assign win_c     = (bus.p0_req & bus.p1_req) ? ~gnt_q : bus.p1_req;
   assign w_we_c    = win_c ? bus.p1_we   : bus.p0_we;
   assign w_be_c    = win_c ? bus.p1_be   : bus.p0_be;
   assign w_addr_c  = win_c ? bus.p1_addr : bus.p0_addr;
   assign w_wdat_c  = win_c ? bus.p1_wdat : bus.p0_wdat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         gnt_q   <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rdat0_q <= '0;
         rdat1_q <= '0;
         addr_q  <= '0;
         dq_o_q  <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req_c) begin
                  state_q <= SETUP;
                  busy_q  <= 1'b1;
                  gnt_q   <= win_c;
                  we_q    <= w_we_c;
                  addr_q  <= w_addr_c;
                  dq_o_q  <= w_wdat_c;
                  ub_n_q  <= ~w_be_c[1];
                  lb_n_q  <= ~w_be_c[0];
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= w_we_c;
                  we_n_q  <= 1'b1;
                  dq_oe_q <= w_we_c;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               cnt_q   <= CNT_W'(ACC_CYCLES - 1);
               oe_n_q  <= we_q;
               we_n_q  <= ~we_q;
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  if (gnt_q) ack1_q <= 1'b1;
                  else       ack0_q <= 1'b1;
                  // Read data is sampled while OE_ is still low
                  if (!we_q) begin
                     if (gnt_q) rdat1_q <= bus.sram_dq_i;
                     else       rdat0_q <= bus.sram_dq_i;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ce_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
               ub_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.p0_ack     = ack0_q;
   assign bus.p1_ack     = ack1_q;
   assign bus.p0_rdat    = rdat0_q;
   assign bus.p1_rdat    = rdat1_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_ce_n  = ce_n_q;
   assign bus.sram_oe_n  = oe_n_q;
   assign bus.sram_we_n  = we_n_q;
   assign bus.sram_ub_n  = ub_n_q;
   assign bus.sram_lb_n  = lb_n_q;
   assign bus.sram_dq_o  = dq_o_q;
   assign bus.sram_dq_oe = dq_oe_q;
   assign bus.busy       = busy_q;
   assign bus.gnt        = gnt_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pad model, timeline-level reference model with per-cycle compare, directed scenarios.
module tb_sram_arbiter;
   localparam int unsigned ACC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_arbiter_if bus ();
   sram_arbiter_if bus1 ();
   sram_arbiter_if bus15 ();

   sram_arbiter #(.ACC_CYCLES(ACC)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
   sram_arbiter #(.ACC_CYCLES(1))   u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
   sram_arbiter #(.ACC_CYCLES(15))  u_dut15 (.clk(clk), .rst(rst), .bus(bus15));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] preload_val(input int i);
      if (i == 3)    return 16'h0008;
      if (i == 'h10) return 16'hFFFF;
      return 16'h0000;
   endfunction

   // ---------------- SRAM pad model (256 words visible) ----------------
   logic [15:0] mem [0:255];
   logic        mem_loaded = 1'b0;
   assign bus.sram_dq_i   = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[7:0]] : 16'hDEAD;
   assign bus1.sram_dq_i  = 16'h0;
   assign bus15.sram_dq_i = 16'h0;

   always @(negedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= preload_val(i);
         mem_loaded <= 1'b1;
      end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
         if (!bus.sram_ub_n) mem[bus.sram_addr[7:0]][15:8] <= bus.sram_dq_o[15:8];
         if (!bus.sram_lb_n) mem[bus.sram_addr[7:0]][7:0]  <= bus.sram_dq_o[7:0];
      end
   end

   // ---------------- reference model: phase 0 idle, 1 setup, 2..ACC+1 strobe, ACC+2 done ----------------
   int unsigned ph = 0;
   logic        mgnt = 1'b1, mport = 1'b0, mwe = 1'b0, gold_loaded = 1'b0;
   logic [1:0]  mbe = 2'b00;
   logic [17:0] maddr = '0;
   logic [15:0] mwdat = '0;
   logic [15:0] erd0 = '0, erd1 = '0;
   logic [15:0] gold [0:255];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         if (!gold_loaded) begin
            for (int i = 0; i < 256; i++) gold[i] <= preload_val(i);
            gold_loaded <= 1'b1;
         end
         ph <= 0; mgnt <= 1'b1; mport <= 1'b0; mwe <= 1'b0; mbe <= 2'b00;
         maddr <= '0; mwdat <= '0; erd0 <= '0; erd1 <= '0;
      end else if (ph == 0) begin
         if (bus.p0_req || bus.p1_req) begin
            automatic logic w = (bus.p0_req && bus.p1_req) ? !mgnt : bus.p1_req;
            mgnt  <= w;
            mport <= w;
            mwe   <= w ? bus.p1_we   : bus.p0_we;
            mbe   <= w ? bus.p1_be   : bus.p0_be;
            maddr <= w ? bus.p1_addr : bus.p0_addr;
            mwdat <= w ? bus.p1_wdat : bus.p0_wdat;
            ph    <= 1;
         end
      end else if (ph == ACC + 2) begin
         ph <= 0;
      end else begin
         ph <= ph + 1;
         if (ph == ACC + 1) begin
            if (mwe)
               gold[maddr[7:0]] <= {mbe[1] ? mwdat[15:8] : gold[maddr[7:0]][15:8],
                                    mbe[0] ? mwdat[7:0]  : gold[maddr[7:0]][7:0]};
            else if (mport) erd1 <= gold[maddr[7:0]];
            else            erd0 <= gold[maddr[7:0]];
         end
      end
   end

   // Per-cycle comparison of the main instance against the model
   always @(negedge clk) begin
      automatic logic act_ph = (ph != 0);
      automatic logic e_oe_n = !(!mwe && ph >= 1 && ph <= ACC + 1);
      automatic logic e_we_n = !( mwe && ph >= 2 && ph <= ACC + 1);
      automatic logic e_dqoe = mwe && act_ph;
      automatic logic e_ub_n = !(act_ph && mbe[1]);
      automatic logic e_lb_n = !(act_ph && mbe[0]);
      automatic logic e_ack0 = (ph == ACC + 2) && !mport;
      automatic logic e_ack1 = (ph == ACC + 2) &&  mport;
      check("strobes", 64'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}),
                       64'({!act_ph, e_oe_n, e_we_n, e_ub_n, e_lb_n, e_dqoe}));
      check("handshake", 64'({bus.busy, bus.gnt, bus.p0_ack, bus.p1_ack}), 64'({act_ph, mgnt, e_ack0, e_ack1}));
      check("addr_wdat", 64'({bus.sram_addr, bus.sram_dq_o}), 64'({maddr, mwdat}));
      check("rdat", 64'({bus.p0_rdat, bus.p1_rdat}), 64'({erd0, erd1}));
      check("oe_we_excl", 64'(!bus.sram_oe_n && !bus.sram_we_n), 64'(0));
      check("dqoe_read", 64'(!bus.sram_oe_n && bus.sram_dq_oe), 64'(0));
   end

   // ---------------- directed stimulus ----------------
   task automatic access(input bit port, input bit we, input logic [1:0] be, input logic [17:0] addr,
                         input logic [15:0] wdat, output int lat, output logic [15:0] rdat,
                         output int oe_cnt, output int we_cnt, output int dqoe_cnt, output int ub_cnt,
                         output int lb_cnt);
      bit got = 0;
      lat = 0; rdat = '0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0; ub_cnt = 0; lb_cnt = 0;
      @(posedge clk); #1;
      if (port) begin
         bus.p1_we = we; bus.p1_be = be; bus.p1_addr = addr; bus.p1_wdat = wdat; bus.p1_req = 1'b1;
      end else begin
         bus.p0_we = we; bus.p0_be = be; bus.p0_addr = addr; bus.p0_wdat = wdat; bus.p0_req = 1'b1;
      end
      for (int n = 1; n <= 60 && !got; n++) begin
         @(posedge clk); #1;
         oe_cnt   += int'(!bus.sram_oe_n);
         we_cnt   += int'(!bus.sram_we_n);
         dqoe_cnt += int'(bus.sram_dq_oe);
         ub_cnt   += int'(!bus.sram_ub_n);
         lb_cnt   += int'(!bus.sram_lb_n);
         if (port ? bus.p1_ack : bus.p0_ack) begin
            got  = 1;
            lat  = n;
            rdat = port ? bus.p1_rdat : bus.p0_rdat;
            if (port) bus.p1_req = 1'b0; else bus.p0_req = 1'b0;
         end
      end
      if (!got) begin
         check("ack_timeout", 64'(0), 64'(1));
         bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int lat, oe_c, we_c, dq_c, ub_c, lb_c;
   logic [15:0] rd;
   int order [0:19];
   int nacc, c0, c1, alt_bad;
   int w1, w15, lat1, lat15;
   bit d1, d15;

   initial begin
      {bus.p0_req, bus.p0_we, bus.p0_be, bus.p0_addr, bus.p0_wdat} = '0;
      {bus.p1_req, bus.p1_we, bus.p1_be, bus.p1_addr, bus.p1_wdat} = '0;
      {bus1.p0_req, bus1.p0_we, bus1.p0_be, bus1.p0_addr, bus1.p0_wdat} = '0;
      {bus1.p1_req, bus1.p1_we, bus1.p1_be, bus1.p1_addr, bus1.p1_wdat} = '0;
      {bus15.p0_req, bus15.p0_we, bus15.p0_be, bus15.p0_addr, bus15.p0_wdat} = '0;
      {bus15.p1_req, bus15.p1_we, bus15.p1_be, bus15.p1_addr, bus15.p1_wdat} = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'({bus.busy, bus.gnt, bus.p0_ack, bus.p1_ack, bus.sram_ce_n, bus.sram_we_n,
                                  bus.sram_oe_n, bus.sram_dq_oe}), 64'(8'b0100_1110));
      check("reset_data", 64'({bus.sram_addr, bus.sram_dq_o, bus.p0_rdat}), 64'(0));
      rst = 1'b0;

      // Port 0 read of preloaded word
      access(0, 0, 2'b11, 18'h00003, 16'h0, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("rd0_latency", 64'(lat), 64'(4));
      check("rd0_data", 64'(rd), 64'(16'h0008));
      check("rd0_oe_width", 64'(oe_c), 64'(3));
      check("rd0_we_idle", 64'(we_c), 64'(0));

      // Port 1 full write, then port 0 readback
      access(1, 1, 2'b11, 18'h00005, 16'hA0B0, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("wr1_we_width", 64'(we_c), 64'(2));
      check("wr1_dqoe_width", 64'(dq_c), 64'(4));
      check("wr1_oe_idle", 64'(oe_c), 64'(0));
      access(0, 0, 2'b11, 18'h00005, 16'h0, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("rb_a0b0", 64'(rd), 64'(16'hA0B0));

      // Lower-byte write over 0xFFFF
      access(1, 1, 2'b01, 18'h00010, 16'h1234, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("bw_ub_off", 64'(ub_c), 64'(0));
      check("bw_lb_on", 64'(lb_c), 64'(4));
      access(1, 0, 2'b11, 18'h00010, 16'h0, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("bw_readback", 64'(rd), 64'(16'hFF34));
      check("p0_rdat_kept", 64'(bus.p0_rdat), 64'(16'hA0B0));

      // be = 00 still completes
      access(0, 1, 2'b00, 18'h00030, 16'h7777, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("be00_latency", 64'(lat), 64'(4));

      // Round robin with both ports requesting continuously
      do_reset();
      bus.p0_we = 0; bus.p0_addr = 18'h00003; bus.p0_be = 2'b11;
      bus.p1_we = 0; bus.p1_addr = 18'h00010; bus.p1_be = 2'b11;
      bus.p0_req = 1; bus.p1_req = 1;
      nacc = 0; c0 = 0; c1 = 0; alt_bad = 0;
      for (int n = 0; n < 400 && nacc < 20; n++) begin
         @(posedge clk); #1;
         if (bus.p0_ack) begin order[nacc] = 0; nacc++; c0++; end
         else if (bus.p1_ack) begin order[nacc] = 1; nacc++; c1++; end
      end
      bus.p0_req = 0; bus.p1_req = 0;
      check("rr_count", 64'(nacc), 64'(20));
      check("rr_first4", 64'({order[0][0], order[1][0], order[2][0], order[3][0]}), 64'(4'b0101));
      for (int i = 1; i < 20; i++) if (order[i] == order[i-1]) alt_bad++;
      check("rr_alternate", 64'(alt_bad), 64'(0));
      check("rr_fair", 64'((c0 > c1 ? c0 - c1 : c1 - c0) <= 1), 64'(1));
      check("rr_p1_data", 64'(bus.p1_rdat), 64'(16'hFF34));
      repeat (6) @(posedge clk);

      // Reset during the strobe phase of a write
      #1;
      bus.p1_we = 1; bus.p1_be = 2'b11; bus.p1_addr = 18'h00020; bus.p1_wdat = 16'h5555; bus.p1_req = 1;
      d1 = 0;
      for (int n = 0; n < 20 && !d1; n++) begin
         @(posedge clk); #1;
         if (!bus.sram_we_n) d1 = 1;
      end
      check("mid_we_seen", 64'(d1), 64'(1));
      #1 rst = 1'b1;
      #1;
      check("async_strobes", 64'({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe, bus.p1_ack, bus.busy}),
                             64'(5'b11000));
      bus.p1_req = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      access(0, 0, 2'b11, 18'h00005, 16'h0, lat, rd, oe_c, we_c, dq_c, ub_c, lb_c);
      check("post_rst_lat", 64'(lat), 64'(4));
      check("post_rst_data", 64'(rd), 64'(16'hA0B0));

      // Strobe width and latency with ACC_CYCLES = 1 and 15
      @(posedge clk); #1;
      bus1.p0_we = 1; bus1.p0_be = 2'b11; bus1.p0_addr = 18'h1; bus1.p0_wdat = 16'h1; bus1.p0_req = 1;
      bus15.p0_we = 1; bus15.p0_be = 2'b11; bus15.p0_addr = 18'h1; bus15.p0_wdat = 16'h1; bus15.p0_req = 1;
      w1 = 0; w15 = 0; lat1 = 0; lat15 = 0; d1 = 0; d15 = 0;
      for (int n = 1; n <= 40 && !(d1 && d15); n++) begin
         @(posedge clk); #1;
         if (!d1) begin
            w1 += int'(!bus1.sram_we_n);
            if (bus1.p0_ack) begin d1 = 1; lat1 = n; bus1.p0_req = 0; end
         end
         if (!d15) begin
            w15 += int'(!bus15.sram_we_n);
            if (bus15.p0_ack) begin d15 = 1; lat15 = n; bus15.p0_req = 0; end
         end
      end
      check("acc1_width", 64'(w1), 64'(1));
      check("acc1_latency", 64'(lat1), 64'(3));
      check("acc15_width", 64'(w15), 64'(15));
      check("acc15_latency", 64'(lat15), 64'(17));

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
